// File: rtl/attention_score_seq_ctrl.sv
// attention_score_seq_ctrl
// Sequences the attention-score flow from a single host start:
//   transpose K, copy K^T from the transpose B-port into the GEMM X SRAM,
//   then launch the Q*K^T GEMM and report completion.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, abort, D_len     host run request (rising edge), abandon, head dim
//   busy, done, err,        run status; done/err are sticky until next start
//   err_code                0 none, 1 zero length, 2 aborted, 3 timeout
//   tr_start, tr_done       transpose launch / completion
//   tr_b_re, tr_b_row,      K^T read port (one read outstanding at a time)
//   tr_b_col, tr_b_rdata, tr_b_rvalid
//   x_we, x_k, x_n,         X SRAM write port
//   x_wdata, x_wmask
//   gemm_start, gemm_busy,  GEMM launch handshake and K length
//   gemm_done, gemm_k_len
// Optional: define ATTN_SEQ_TIMEOUT_EN to add a TO_CYC-cycle watchdog on the
// transpose wait, read-response wait and GEMM wait (error code 3).
module attention_score_seq_ctrl #(
  parameter int T      = 8,
  parameter int DMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int TO_CYC = 65535,
  parameter int T_W    = (T > 1) ? $clog2(T) : 1,
  parameter int D_W    = (DMAX > 1) ? $clog2(DMAX) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       D_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              tr_start,
  input  logic              tr_done,
  output logic              tr_b_re,
  output logic [D_W-1:0]    tr_b_row,
  output logic [T_W-1:0]    tr_b_col,
  input  logic [DATA_W-1:0] tr_b_rdata,
  input  logic              tr_b_rvalid,
  output logic              x_we,
  output logic [D_W-1:0]    x_k,
  output logic [T_W-1:0]    x_n,
  output logic [DATA_W-1:0] x_wdata,
  output logic [BYTE_W-1:0] x_wmask,
  output logic              gemm_start,
  input  logic              gemm_busy,
  input  logic              gemm_done,
  output logic [15:0]       gemm_k_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_TR_GO, S_TR_WAIT, S_COPY, S_GEMM_GO, S_GEMM_WAIT, S_ERR
  } state_t;

  localparam logic [T_W-1:0] T_LAST = T_W'(T - 1);

  state_t              state, state_n;
  logic                start_d;
  logic [D_W-1:0]      d_q, d_n;
  logic [T_W-1:0]      t_q, t_n;
  logic [D_W-1:0]      wk_q, wk_n;
  logic [T_W-1:0]      wn_q, wn_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic                issue_q, issue_n;  // first read of the copy is due
  logic                pend_q, pend_n;    // a read is outstanding
  logic                wr_q, wr_n;        // captured data is written this cycle
  logic                last_q, last_n;    // captured element is the final one
  logic                done_q, done_n;
  logic                err_q, err_n;
  logic [1:0]          code_q, code_n;
  logic [15:0]         klen_q, klen_n;
  logic                accept;
  logic [15:0]         d_eff;
  logic                wait_cyc;
`ifdef ATTN_SEQ_TIMEOUT_EN
  logic [31:0]         wd_q, wd_n;
`else
  // TO_CYC only matters when the watchdog is built in.
  if (TO_CYC < 1) begin : g_to_cyc_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_d <= 1'b0;
      d_q     <= '0;
      t_q     <= '0;
      wk_q    <= '0;
      wn_q    <= '0;
      rdata_q <= '0;
      issue_q <= 1'b0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      klen_q  <= '0;
`ifdef ATTN_SEQ_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state   <= state_n;
      start_d <= start;
      d_q     <= d_n;
      t_q     <= t_n;
      wk_q    <= wk_n;
      wn_q    <= wn_n;
      rdata_q <= rdata_n;
      issue_q <= issue_n;
      pend_q  <= pend_n;
      wr_q    <= wr_n;
      last_q  <= last_n;
      done_q  <= done_n;
      err_q   <= err_n;
      code_q  <= code_n;
      klen_q  <= klen_n;
`ifdef ATTN_SEQ_TIMEOUT_EN
      wd_q    <= wd_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    d_n        = d_q;
    t_n        = t_q;
    wk_n       = wk_q;
    wn_n       = wn_q;
    rdata_n    = rdata_q;
    issue_n    = issue_q;
    pend_n     = pend_q;
    wr_n       = wr_q;
    last_n     = last_q;
    done_n     = done_q;
    err_n      = err_q;
    code_n     = code_q;
    klen_n     = klen_q;
    tr_start   = 1'b0;
    tr_b_re    = 1'b0;
    x_we       = 1'b0;
    gemm_start = 1'b0;
    wait_cyc   = 1'b0;
    accept     = (state == S_IDLE) && start && !start_d;
    d_eff      = (D_len > 16'(DMAX)) ? 16'(DMAX) : D_len;

    case (state)
      S_IDLE: begin
        if (accept) begin
          done_n = 1'b0;
          err_n  = 1'b0;
          code_n = 2'd0;
          klen_n = d_eff;
          if (d_eff == 16'd0) begin
            state_n = S_ERR;
            err_n   = 1'b1;
            code_n  = 2'd1;
          end else begin
            state_n = S_TR_GO;
          end
        end
      end
      S_TR_GO: begin
        tr_start = 1'b1;
        state_n  = S_TR_WAIT;
      end
      S_TR_WAIT: begin
        if (tr_done) begin
          state_n = S_COPY;
          d_n     = '0;
          t_n     = '0;
          issue_n = 1'b1;
          pend_n  = 1'b0;
          wr_n    = 1'b0;
          last_n  = 1'b0;
        end else begin
          wait_cyc = 1'b1;
        end
      end
      S_COPY: begin
        // d_q/t_q always hold the next read address; the write address is
        // snapshotted at capture so the next read can go out with the write.
        if (issue_q) begin
          tr_b_re = 1'b1;
          issue_n = 1'b0;
          pend_n  = 1'b1;
        end else if (pend_q) begin
          if (tr_b_rvalid) begin
            rdata_n = tr_b_rdata;
            wk_n    = d_q;
            wn_n    = t_q;
            wr_n    = 1'b1;
            pend_n  = 1'b0;
            last_n  = (t_q == T_LAST) && (16'(d_q) == klen_q - 16'd1);
            if (!last_n) begin
              if (t_q == T_LAST) begin
                t_n = '0;
                d_n = d_q + D_W'(1);
              end else begin
                t_n = t_q + T_W'(1);
              end
            end
          end else begin
            wait_cyc = 1'b1;
          end
        end else if (wr_q) begin
          x_we = 1'b1;
          wr_n = 1'b0;
          if (last_q) begin
            state_n = S_GEMM_GO;
          end else begin
            tr_b_re = 1'b1;
            pend_n  = 1'b1;
          end
        end
      end
      S_GEMM_GO: begin
        if (!gemm_busy) begin
          gemm_start = 1'b1;
          state_n    = S_GEMM_WAIT;
        end
      end
      S_GEMM_WAIT: begin
        if (gemm_done) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          wait_cyc = 1'b1;
        end
      end
      S_ERR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

`ifdef ATTN_SEQ_TIMEOUT_EN
    wd_n = '0;
    if (wait_cyc) begin
      if (wd_q == 32'(TO_CYC - 1)) begin
        state_n = S_ERR;
        err_n   = 1'b1;
        code_n  = 2'd3;
        pend_n  = 1'b0;
      end else begin
        wd_n = wd_q + 32'd1;
      end
    end
`endif

    // Abort overrides everything outside IDLE, including this cycle's strobes.
    if (abort && state != S_IDLE) begin
      state_n    = S_IDLE;
      err_n      = 1'b1;
      code_n     = 2'd2;
      done_n     = 1'b0;
      issue_n    = 1'b0;
      pend_n     = 1'b0;
      wr_n       = 1'b0;
      tr_start   = 1'b0;
      tr_b_re    = 1'b0;
      x_we       = 1'b0;
      gemm_start = 1'b0;
`ifdef ATTN_SEQ_TIMEOUT_EN
      wd_n       = '0;
`endif
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign tr_b_row   = d_q;
  assign tr_b_col   = t_q;
  assign x_k        = wk_q;
  assign x_n        = wn_q;
  assign x_wdata    = rdata_q;
  assign x_wmask    = {BYTE_W{x_we}};
  assign gemm_k_len = klen_q;

endmodule

// File: tb/tb_attention_score_seq_ctrl.sv
// Directed bench for attention_score_seq_ctrl with T=4, DMAX=16, TO_CYC=100.
// A transpose B-port responder returns rdata = {row,col} two cycles after each
// read; expected X writes are queued when a run is launched and checked in
// order as the DUT writes them.
module tb_attention_score_seq_ctrl;

  localparam int T   = 4;
  localparam int TW  = 2;
  localparam int DW  = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, tr_done, tr_b_rvalid, gemm_busy, gemm_done;
  logic [15:0]   D_len;
  logic          busy, done, err, tr_start, tr_b_re, x_we, gemm_start;
  logic [1:0]    err_code;
  logic [DW-1:0] tr_b_row, x_k;
  logic [TW-1:0] tr_b_col, x_n;
  logic [31:0]   tr_b_rdata, x_wdata;
  logic [3:0]    x_wmask;
  logic [15:0]   gemm_k_len;

  attention_score_seq_ctrl #(.T(4), .DMAX(16), .DATA_W(32), .TO_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .D_len(D_len),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .tr_start(tr_start), .tr_done(tr_done), .tr_b_re(tr_b_re),
    .tr_b_row(tr_b_row), .tr_b_col(tr_b_col), .tr_b_rdata(tr_b_rdata),
    .tr_b_rvalid(tr_b_rvalid), .x_we(x_we), .x_k(x_k), .x_n(x_n),
    .x_wdata(x_wdata), .x_wmask(x_wmask), .gemm_start(gemm_start),
    .gemm_busy(gemm_busy), .gemm_done(gemm_done), .gemm_k_len(gemm_k_len)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] k; logic [TW-1:0] n; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cnt_trs, cnt_re, cnt_we, cnt_gs;
  logic [DW-1:0] last_k;
  logic [TW-1:0] last_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Read responder: two-cycle latency, data = {row, col}.
  logic        s1v, s2v;
  logic [31:0] s1d, s2d;
  initial begin
    s1v = 0; s2v = 0; s1d = '0; s2d = '0;
    tr_b_rvalid = 0; tr_b_rdata = '0;
  end
  always @(negedge clk) begin
    tr_b_rvalid = s2v;
    tr_b_rdata  = s2d;
    s2v = s1v;
    s2d = s1d;
    s1v = tr_b_re;
    s1d = 32'({tr_b_row, tr_b_col});
  end

  // Monitor and scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    if (tr_start) cnt_trs++;
    if (tr_b_re) cnt_re++;
    if (gemm_start) begin
      cnt_gs++;
      chk("gemm_start_while_busy", 32'(gemm_busy), 32'd0);
    end
    if (x_we) begin
      cnt_we++;
      last_k = x_k;
      last_n = x_n;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL x_we_unexpected observed k=%0d n=%0d expected no write", x_k, x_n);
      end else begin
        e = exp_q.pop_front();
        chk("x_k", 32'(x_k), 32'(e.k));
        chk("x_n", 32'(x_n), 32'(e.n));
        chk("x_wdata", x_wdata, e.data);
        chk("x_wmask", 32'(x_wmask), 32'hF);
      end
    end
  end

  task automatic clear_counts();
    cnt_trs = 0; cnt_re = 0; cnt_we = 0; cnt_gs = 0;
  endtask

  task automatic push_expected(input int deff);
    wr_t e;
    for (int d = 0; d < deff; d++)
      for (int t = 0; t < T; t++) begin
        e.k = DW'(d); e.n = TW'(t); e.data = 32'(d * 4 + t);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_trs();
    for (int i = 0; i < 20 && cnt_trs < 1; i++) step(1);
    chk("tr_start_seen", 32'(cnt_trs), 32'd1);
  endtask

  task automatic wait_we(input int n);
    for (int i = 0; i < 2000 && cnt_we < n; i++) step(1);
  endtask

  task automatic run_flow(input logic [15:0] dlen, input int busy_cyc, input bit hold);
    int deff, n;
    deff = (dlen > 16) ? 16 : int'(dlen);
    n = deff * T;
    clear_counts();
    push_expected(deff);
    gemm_busy = (busy_cyc > 0);
    D_len = dlen;
    start = 1;
    step(1);
    if (!hold) start = 0;
    wait_trs();
    step(1);
    tr_done = 1;
    step(1);
    tr_done = 0;
    wait_we(n);
    chk("writes", 32'(cnt_we), 32'(n));
    chk("reads", 32'(cnt_re), 32'(n));
    chk("last_x_k", 32'(last_k), 32'(deff - 1));
    chk("last_x_n", 32'(last_n), 32'(T - 1));
    chk("gemm_k_len", 32'(gemm_k_len), 32'(deff));
    if (busy_cyc > 0) begin
      step(busy_cyc - 1);
      chk("no_gemm_start_while_busy", 32'(cnt_gs), 32'd0);
      gemm_busy = 0;
    end
    @(negedge clk);
    chk("gemm_start_now", 32'(gemm_start), 32'd1);
    step(2);
    gemm_done = 1;
    step(1);
    gemm_done = 0;
    chk("done", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("err_after_done", 32'(err), 32'd0);
    step(5);
    chk("gemm_start_count", 32'(cnt_gs), 32'd1);
    chk("tr_start_count", 32'(cnt_trs), 32'd1);
    chk("busy_stays_low", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    start = 0;
  endtask

  initial begin
    int we_snap;
    rst_n = 0; start = 0; abort = 0; tr_done = 0; gemm_busy = 0; gemm_done = 0;
    D_len = '0;
    clear_counts();
    step(3);
    rst_n = 1;
    step(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_strobes", 32'({tr_start, tr_b_re, x_we, gemm_start}), 32'd0);
    chk("rst_gemm_k_len", 32'(gemm_k_len), 32'd0);

    // Nominal run, D_len = 8.
    run_flow(16'd8, 0, 0);

    // Zero length.
    clear_counts();
    D_len = 16'd0;
    start = 1;
    step(1);
    start = 0;
    chk("zero_err", 32'(err), 32'd1);
    chk("zero_err_code", 32'(err_code), 32'd1);
    chk("zero_done_clear", 32'(done), 32'd0);
    step(5);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_no_strobes", 32'(cnt_trs + cnt_we + cnt_gs + cnt_re), 32'd0);

    // Oversize length clamps to DMAX.
    run_flow(16'd40, 0, 0);

    // Abort after the fifth write.
    clear_counts();
    push_expected(8);
    D_len = 16'd8;
    start = 1;
    step(1);
    start = 0;
    wait_trs();
    step(1);
    tr_done = 1;
    step(1);
    tr_done = 0;
    wait_we(5);
    chk("abort_at_5", 32'(cnt_we), 32'd5);
    abort = 1;
    step(1);
    abort = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_err_code", 32'(err_code), 32'd2);
    chk("abort_done", 32'(done), 32'd0);
    step(30);
    chk("abort_no_more_we", 32'(cnt_we), 32'd5);
    chk("abort_no_gemm", 32'(cnt_gs), 32'd0);
    exp_q.delete();

    // Clean run after abort, with start held and GEMM busy for 10 cycles.
    run_flow(16'd3, 10, 1);
    chk("err_cleared", 32'(err_code), 32'd0);

    // Abort while idle changes nothing.
    abort = 1;
    step(2);
    abort = 0;
    chk("idle_abort_done", 32'(done), 32'd1);
    chk("idle_abort_err", 32'(err), 32'd0);

    // Reset in the middle of a copy.
    clear_counts();
    D_len = 16'd8;
    start = 1;
    step(1);
    start = 0;
    wait_trs();
    step(1);
    tr_done = 1;
    step(1);
    tr_done = 0;
    push_expected(8);
    wait_we(3);
    rst_n = 0;
    step(2);
    rst_n = 1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_flags", 32'({done, err, err_code}), 32'd0);
    chk("midrst_klen", 32'(gemm_k_len), 32'd0);
    we_snap = cnt_we;
    step(20);
    chk("midrst_no_we", 32'(cnt_we), 32'(we_snap));
    chk("midrst_no_gemm", 32'(cnt_gs), 32'd0);
    exp_q.delete();

`ifdef ATTN_SEQ_TIMEOUT_EN
    // tr_done never arrives: timeout exactly 100 cycles after TR_WAIT entry.
    clear_counts();
    D_len = 16'd2;
    start = 1;
    step(1);
    start = 0;
    wait_trs();
    step(99);
    chk("to_not_yet", 32'(err), 32'd0);
    step(1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_err_code", 32'(err_code), 32'd3);
    step(2);
    chk("to_busy", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
